// File: rtl/sr_seq_pkg.sv
// Shared definitions for the SR command sequencer: FSM encoding, default timing
// parameters and a counter-width helper.
package sr_seq_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StWaitFb = 2'd2
    } state_e;

    localparam int unsigned DefDbCycles = 4;
    localparam int unsigned DefTimeout  = 8;

    // Bits needed to hold any value in 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        cnt_width = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) <= {32'd0, max_val}) cnt_width = i + 1;
        end
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// One request channel: 2-flop synchroniser, stability counter and a registered
// single-cycle pulse on each debounced rising edge.
module sr_debounce
    import sr_seq_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DefDbCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    output logic rise_o
);

    localparam int unsigned CW = cnt_width(DB_CYCLES);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          differ, hit;

    always_comb begin
        differ  = sync_q[1] ^ level_q;
        hit     = differ && (cnt_q == CW'(DB_CYCLES - 1));
        cnt_d   = '0;
        if (differ && !hit) cnt_d = cnt_q + 1'b1;
        level_d = level_q ^ hit;
        rise_d  = hit && !level_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], req_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Turns raw set/reset requests into clean, mutually exclusive S/R pulses for a
// downstream SR flop and watches Q follow each command with a timeout.
module sr_cmd_sequencer
    import sr_seq_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DefDbCycles,
    parameter int unsigned TIMEOUT   = DefTimeout,
    parameter bit          SET_WINS  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic rst_req,
    input  logic q_fb,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic err
);

    localparam int unsigned TW = cnt_width(TIMEOUT);

    logic          rise_set, rise_rst;
    logic          pend_set_q, pend_set_d, pend_rst_q, pend_rst_d;
    logic          take_set, take_rst, in_idle;
    state_e        state_q;
    logic          target_q;
    logic [TW-1:0] tcnt_q;
    logic          s_q, r_q, busy_q, conflict_q, err_q;

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_dbc_set (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req_i  (set_req),
        .rise_o (rise_set)
    );

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_dbc_rst (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req_i  (rst_req),
        .rise_o (rise_rst)
    );

    // Every pend seen in IDLE is consumed: taken, dropped as redundant or lost
    // to arbitration. A rise arriving in the same cycle still lands.
    always_comb begin
        in_idle    = (state_q == StIdle);
        pend_set_d = (pend_set_q && !in_idle) || rise_set;
        pend_rst_d = (pend_rst_q && !in_idle) || rise_rst;
        take_set   = pend_set_q && (!pend_rst_q || SET_WINS);
        take_rst   = pend_rst_q && (!pend_set_q || !SET_WINS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_set_q <= 1'b0;
            pend_rst_q <= 1'b0;
        end else begin
            pend_set_q <= pend_set_d;
            pend_rst_q <= pend_rst_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            target_q   <= 1'b0;
            tcnt_q     <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pend_set_q && pend_rst_q) conflict_q <= 1'b1;
                    if (take_set && !q_fb) begin
                        target_q <= 1'b1;
                        s_q      <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= StIssue;
                    end else if (take_rst && q_fb) begin
                        target_q <= 1'b0;
                        r_q      <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    tcnt_q  <= '0;
                    state_q <= StWaitFb;
                end
                StWaitFb: begin
                    if (q_fb == target_q) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed bench for sr_cmd_sequencer: a cycle model of the command rules checked
// every cycle, plus hand-computed latency and pulse-count expectations.
module tb_sr_cmd_sequencer;

    localparam int DB = 4;
    localparam int TO = 8;
    localparam bit SW = 1'b0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_req = 1'b0;
    logic rst_req = 1'b0;
    logic tie0 = 1'b0;
    logic q_sr = 1'b0;
    logic q_fb;
    logic S, R, busy, conflict, err;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Downstream SR flop, optionally disconnected from the feedback path.
    always @(posedge clk) begin
        if (S) q_sr <= 1'b1;
        else if (R) q_sr <= 1'b0;
    end
    assign q_fb = tie0 ? 1'b0 : q_sr;

    sr_cmd_sequencer #(
        .DB_CYCLES (DB),
        .TIMEOUT   (TO),
        .SET_WINS  (SW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_req  (set_req),
        .rst_req  (rst_req),
        .q_fb     (q_fb),
        .S        (S),
        .R        (R),
        .busy     (busy),
        .conflict (conflict),
        .err      (err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model state; channel 0 = set, 1 = reset. phase: 0 idle, 1 issue, 2 waiting.
    int m_sync1[2], m_sync2[2], m_lvl[2], m_run[2], m_rise[2], m_pend[2];
    int m_phase, m_target, m_tcnt;
    int m_S, m_R, m_busy, m_conf, m_err;
    int raw[2];
    int was_idle, want_s, want_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                m_sync1[c] = 0; m_sync2[c] = 0; m_lvl[c] = 0;
                m_run[c] = 0; m_rise[c] = 0; m_pend[c] = 0;
            end
            m_phase = 0; m_target = 0; m_tcnt = 0;
            m_S = 0; m_R = 0; m_busy = 0; m_conf = 0; m_err = 0;
        end else begin
            raw[0] = int'(set_req);
            raw[1] = int'(rst_req);
            was_idle = (m_phase == 0) ? 1 : 0;
            m_S = 0; m_R = 0; m_conf = 0;
            if (m_phase == 0) begin
                if (m_pend[0] != 0 && m_pend[1] != 0) m_conf = 1;
                want_s = (m_pend[0] != 0 && (m_pend[1] == 0 || SW)) ? 1 : 0;
                want_r = (m_pend[1] != 0 && (m_pend[0] == 0 || !SW)) ? 1 : 0;
                if (want_s != 0 && q_fb == 1'b0) begin
                    m_target = 1; m_S = 1; m_phase = 1;
                end else if (want_r != 0 && q_fb == 1'b1) begin
                    m_target = 0; m_R = 1; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
                m_tcnt = 0;
            end else begin
                if (int'(q_fb) == m_target) m_phase = 0;
                else if (m_tcnt + 1 == TO) begin
                    m_err = 1;
                    m_phase = 0;
                end else m_tcnt++;
            end
            m_busy = (m_phase != 0) ? 1 : 0;
            for (int c = 0; c < 2; c++) begin
                m_pend[c] = ((was_idle != 0) ? 0 : m_pend[c]) | m_rise[c];
                m_rise[c] = 0;
                if (m_sync2[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB) begin
                        m_lvl[c] = 1 - m_lvl[c];
                        m_run[c] = 0;
                        m_rise[c] = m_lvl[c];
                    end
                end else m_run[c] = 0;
                m_sync2[c] = m_sync1[c];
                m_sync1[c] = raw[c];
            end
        end
    end

    int prev_sr = 0;
    always @(negedge clk) begin
        check("cycle S", int'(S), m_S);
        check("cycle R", int'(R), m_R);
        check("cycle busy", int'(busy), m_busy);
        check("cycle conflict", int'(conflict), m_conf);
        check("cycle err", int'(err), m_err);
        check("S and R exclusive", int'(S & R), 0);
        check("no back-to-back pulse", prev_sr & int'(S | R), 0);
        prev_sr = rst_n ? int'(S | R) : 0;
    end

    task automatic run_count(input int n, output int ns, output int nr, output int nb,
                             output int nc);
        ns = 0; nr = 0; nb = 0; nc = 0;
        repeat (n) begin
            @(negedge clk);
            ns += int'(S); nr += int'(R); nb += int'(busy); nc += int'(conflict);
        end
    endtask

    // Edges from the drive until S is seen, minus one: the first sampling edge is edge 0.
    task automatic wait_for_s(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (S) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    initial begin
        int ns, nr, nb, nc, lat, tot_r, tot_b, errdel;

        repeat (3) @(negedge clk);
        check("reset S", int'(S), 0);
        check("reset R", int'(R), 0);
        check("reset busy", int'(busy), 0);
        check("reset conflict", int'(conflict), 0);
        check("reset err", int'(err), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean set
        set_req = 1'b1;
        wait_for_s(lat);
        check("clean set latency", lat, 7);
        nb = int'(busy);
        @(posedge clk); #1;
        check("clean set Q next cycle", int'(q_sr), 1);
        nb += int'(busy);
        repeat (5) begin
            @(posedge clk); #1;
            nb += int'(busy);
        end
        check("clean set busy cycles", nb, 2);
        check("clean set err", int'(err), 0);
        @(negedge clk);
        set_req = 1'b0;
        run_count(12, ns, nr, nb, nc);

        // Bouncing reset request with Q=1 must never reach R
        tot_r = 0; tot_b = 0;
        for (int k = 0; k < 6; k++) begin
            rst_req = (k % 2 == 0);
            run_count(2, ns, nr, nb, nc);
            tot_r += nr; tot_b += nb;
        end
        rst_req = 1'b0;
        run_count(20, ns, nr, nb, nc);
        tot_r += nr; tot_b += nb;
        check("bounce R pulses", tot_r, 0);
        check("bounce busy cycles", tot_b, 0);

        // Simultaneous requests, reset wins, Q=1
        set_req = 1'b1; rst_req = 1'b1;
        run_count(16, ns, nr, nb, nc);
        check("conflict pulses", nc, 1);
        check("conflict R pulses", nr, 1);
        check("conflict S pulses", ns, 0);
        check("conflict Q", int'(q_sr), 0);
        set_req = 1'b0; rst_req = 1'b0;
        run_count(12, ns, nr, nb, nc);

        // Redundant reset with Q=0
        rst_req = 1'b1;
        run_count(14, ns, nr, nb, nc);
        check("redundant reset R pulses", nr, 0);
        check("redundant reset busy", nb, 0);
        rst_req = 1'b0;
        run_count(10, ns, nr, nb, nc);

        // Set to Q=1, then a redundant set
        set_req = 1'b1;
        run_count(14, ns, nr, nb, nc);
        check("second set S pulses", ns, 1);
        check("second set Q", int'(q_sr), 1);
        set_req = 1'b0;
        run_count(10, ns, nr, nb, nc);
        set_req = 1'b1;
        run_count(14, ns, nr, nb, nc);
        check("redundant set S pulses", ns, 0);
        check("redundant set busy", nb, 0);
        set_req = 1'b0;
        run_count(10, ns, nr, nb, nc);

        // Timeout: feedback stuck at 0
        tie0 = 1'b1;
        set_req = 1'b1;
        wait_for_s(lat);
        check("timeout set latency", lat, 7);
        errdel = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (err && errdel < 0) errdel = k - 1;
        end
        check("err delay after WAIT_FB entry", errdel, TO);
        @(negedge clk);
        set_req = 1'b0; rst_req = 1'b1;
        run_count(14, ns, nr, nb, nc);
        check("post-timeout reset R pulses", nr, 0);
        check("post-timeout busy", nb, 0);
        check("err sticky", int'(err), 1);
        rst_req = 1'b0;
        run_count(10, ns, nr, nb, nc);

        // Reconnect feedback, clear Q, then reset during the S cycle
        tie0 = 1'b0;
        rst_req = 1'b1;
        run_count(14, ns, nr, nb, nc);
        check("err does not block R", nr, 1);
        check("reset Q", int'(q_sr), 0);
        rst_req = 1'b0;
        run_count(10, ns, nr, nb, nc);
        set_req = 1'b1;
        wait_for_s(lat);
        check("pre-abort set latency", lat, 7);
        #2 rst_n = 1'b0;
        #1;
        check("abort S", int'(S), 0);
        check("abort R", int'(R), 0);
        check("abort busy", int'(busy), 0);
        check("abort conflict", int'(conflict), 0);
        check("abort err cleared", int'(err), 0);
        set_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_count(16, ns, nr, nb, nc);
        check("after abort S pulses", ns, 0);
        check("after abort busy", nb, 0);
        set_req = 1'b1;
        wait_for_s(lat);
        check("after abort new set latency", lat, 7);
        @(negedge clk);
        set_req = 1'b0;
        run_count(12, ns, nr, nb, nc);
        check("final Q", int'(q_sr), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
